// File: rtl/bit_synchronizer.sv
`default_nettype none
// ============================================================================
//  Module   : bit_synchronizer
//  Purpose  : Multi-flop synchroniser that brings a single asynchronous bit
//             into the clk domain. It can be reused for any asynchronous
//             level input.
//  Ports    : clk        - destination clock, rising edge
//             resetPulse - asynchronous active-high reset; loads RESET_VAL
//                          into every stage
//             d          - asynchronous input bit
//             q          - synchronised output (last stage of the chain)
//  Revision : 1.0 - initial release
// ============================================================================
module bit_synchronizer #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic resetPulse,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_chain;

    // Every stage is preset to RESET_VAL so that the output does not show a
    // false transition when reset is released.
    always_ff @(posedge clk or posedge resetPulse) begin
        if (resetPulse) begin
            sync_chain <= {STAGES{RESET_VAL}};
        end else begin
            sync_chain <= {sync_chain[STAGES-2:0], d};
        end
    end

    assign q = sync_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/button_sync_pulse.sv
`default_nettype none
// ============================================================================
//  Module   : button_sync_pulse
//  Purpose  : Converts a raw, bouncing, active-low push-button into a single
//             one-cycle pulse for each debounced press. The input is first
//             synchronised, then debounced, and then the press edge is
//             detected. Releases produce no pulse.
//  Ports    : clk         - system clock, rising edge
//             resetPulse  - asynchronous active-high reset
//             button      - raw button level (0 = pressed, 1 = released)
//             buttonPulse - registered one-cycle pulse per debounced press
//  Revision : 1.0 - initial release
// ============================================================================
module button_sync_pulse #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int SYNC_STAGES     = 2,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic resetPulse,
    input  logic button,
    output logic buttonPulse
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_s;
    logic             btn_db;
    logic             btn_db_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    bit_synchronizer #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk        (clk),
        .resetPulse (resetPulse),
        .d          (button),
        .q          (btn_s)
    );

    // The counter only runs while the synchronised level disagrees with the
    // accepted level. Any return to agreement clears it, so a bounce restarts
    // the qualification window. It is cleared on acceptance and never passes
    // CNT_MAX.
    always_comb begin
        btn_db_next = btn_db;
        cnt_next    = '0;
        if (btn_s != btn_db) begin
            if (cnt == CNT_MAX) begin
                btn_db_next = btn_s;
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end
    end

    // The pulse uses the next accepted level, so it is asserted on the same
    // edge on which the accepted level falls from 1 to 0.
    always_ff @(posedge clk or posedge resetPulse) begin
        if (resetPulse) begin
            btn_db      <= 1'b1;
            cnt         <= '0;
            buttonPulse <= 1'b0;
        end else begin
            btn_db      <= btn_db_next;
            cnt         <= cnt_next;
            buttonPulse <= btn_db & ~btn_db_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_button_sync_pulse.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_sync_pulse
//  Purpose  : Self-checking bench for button_sync_pulse. It uses a run-length
//             reference model of the synchronise, debounce and press-detect
//             behaviour, and applies directed scenarios followed by
//             randomised button activity.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_button_sync_pulse;

    localparam int D = 6;
    localparam int S = 3;

    logic clk = 1'b0;
    logic resetPulse;
    logic button;
    logic buttonPulse;

    int checks = 0;
    int errors = 0;

    button_sync_pulse #(
        .DEBOUNCE_CYCLES (D),
        .SYNC_STAGES     (S)
    ) dut (
        .clk         (clk),
        .resetPulse  (resetPulse),
        .button      (button),
        .buttonPulse (buttonPulse)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // hist holds the last S sampled button values; the oldest entry is what
    // the debouncer sees at this edge. run counts consecutive edges where the
    // seen level disagrees with the accepted level.
    bit hist[$];
    bit acc;
    int run;
    bit exp_pulse;
    int pulses_seen = 0;
    int pulses_exp  = 0;

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < S; i++) hist.push_back(1'b1);
        acc       = 1'b1;
        run       = 0;
        exp_pulse = 1'b0;
    endfunction

    function automatic void model_step(bit b);
        bit seen;
        seen = hist.pop_front();
        hist.push_back(b);
        exp_pulse = 1'b0;
        if (seen != acc) begin
            run++;
            if (run == D) begin
                exp_pulse = acc && !seen;
                acc       = seen;
                run       = 0;
            end
        end else begin
            run = 0;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: advance the model with the value sampled at this edge, then
    // compare the DUT output just after the edge.
    task automatic tick();
        @(posedge clk);
        if (!resetPulse) model_step(button);
        #1;
        check("pulse", {31'd0, buttonPulse}, {31'd0, exp_pulse});
        check("cnt_range", {31'd0, (dut.cnt <= 3'(D - 1))}, 32'd1);
        if (buttonPulse === 1'b1) pulses_seen++;
        if (exp_pulse) pulses_exp++;
    endtask

    task automatic hold(input bit level, input int n);
        button = level;
        repeat (n) tick();
    endtask

    // Asserts reset between edges and holds it for n edges; rnd scrambles the
    // button during reset, otherwise the button is left as it is.
    task automatic apply_reset(input int n, input bit rnd);
        @(negedge clk);
        resetPulse = 1'b1;
        model_reset();
        #1;
        check("rst_pulse_now", {31'd0, buttonPulse}, 32'd0);
        for (int i = 0; i < n; i++) begin
            if (rnd) button = 1'($urandom);
            tick();
        end
        @(negedge clk);
        resetPulse = 1'b0;
    endtask

    // Counts edges from the next one (edge 0) until a pulse appears.
    task automatic measure_latency(input string tag);
        int k;
        for (k = 0; k < 10 * D; k++) begin
            tick();
            if (buttonPulse === 1'b1) break;
        end
        check(tag, k, S + D - 1);
    endtask

    int base;

    initial begin
        resetPulse = 1'b1;
        button     = 1'b1;
        model_reset();
        #2;
        check("reset_pulse", {31'd0, buttonPulse}, 32'd0);
        check("reset_db", {31'd0, dut.btn_db}, 32'd1);
        check("reset_cnt", {29'd0, dut.cnt}, 32'd0);
        repeat (3) tick();
        @(negedge clk);
        resetPulse = 1'b0;

        // 1. normal press with latency and width
        hold(1'b1, 2 * D);
        base = pulses_seen;
        button = 1'b0;
        measure_latency("normal_latency");
        tick();
        check("normal_width", {31'd0, buttonPulse}, 32'd0);
        hold(1'b0, 5 * D);
        hold(1'b1, 2 * D);
        check("normal_count", pulses_seen - base, 1);

        // 2. press entirely during reset
        base = pulses_seen;
        @(negedge clk);
        resetPulse = 1'b1;
        model_reset();
        hold(1'b0, 2 * D);
        hold(1'b1, D);
        @(negedge clk);
        resetPulse = 1'b0;
        hold(1'b1, 2 * D);
        check("reset_press_count", pulses_seen - base, 0);

        // 3. bounce rejection then hold low
        base = pulses_seen;
        for (int i = 0; i < 10; i++) begin
            hold(1'b0, 2);
            hold(1'b1, 2);
        end
        button = 1'b0;
        measure_latency("bounce_latency");
        hold(1'b0, 2 * D);
        hold(1'b1, 3 * D);
        check("bounce_count", pulses_seen - base, 1);

        // 4. glitch one edge short of the window, then exactly the window
        base = pulses_seen;
        hold(1'b0, D - 1);
        hold(1'b1, S + 1);
        check("glitch_cnt_clear", {29'd0, dut.cnt}, 32'd0);
        hold(1'b1, 2 * D);
        check("glitch_count", pulses_seen - base, 0);
        base = pulses_seen;
        hold(1'b0, D);
        hold(1'b1, 3 * D);
        check("window_exact_count", pulses_seen - base, 1);

        // 5. reset in the middle of a count, button stays held
        base = pulses_seen;
        hold(1'b0, S + D / 2);
        apply_reset(3, 1'b0);
        measure_latency("post_reset_latency");
        hold(1'b0, 2 * D);
        hold(1'b1, 3 * D);
        check("reset_mid_count", pulses_seen - base, 1);

        // 6. three press/release cycles
        base = pulses_seen;
        for (int i = 0; i < 3; i++) begin
            hold(1'b0, 2 * D);
            hold(1'b1, 2 * D);
        end
        check("repeat_count", pulses_seen - base, 3);

        // 7. random runs with occasional reset
        base = pulses_exp;
        begin
            int seen0;
            seen0 = pulses_seen;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 49) == 0) apply_reset($urandom_range(1, 4), 1'b1);
                else hold(1'($urandom), $urandom_range(1, 2 * D));
            end
            hold(1'b1, 3 * D);
            check("random_count", pulses_seen - seen0, pulses_exp - base);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
